video_src_arbiter: RTL and testbench



---
 rtl/video_src_arbiter_if.sv | 82 ++++++++
 rtl/video_src_arbiter.sv | 257 +++++++++++++++++++++++++
 tb/tb_video_src_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/video_src_arbiter_if.sv
// Video source arbiter bus: control handshake, the two source streams, pattern reset and
// the arbitrated output stream.
interface video_src_arbiter_if #(
  parameter int unsigned DW = 10
);

  // Switch control and status
  logic          sel_req;
  logic          sel_src;
  logic          sel_busy;
  logic          sw_done;
  logic          sw_err;
  logic          fallback;
  logic          cur_src;

  // Source 0: sensor
  logic          s0_de;
  logic [DW-1:0] s0_data;
  logic          s0_hsync;
  logic          s0_vsync;

  // Source 1: test-pattern generator
  logic          s1_de;
  logic [DW-1:0] s1_data;
  logic          s1_hsync;
  logic          s1_vsync;

  logic          pg_rstn;

  // Arbitrated output
  logic          out_de;
  logic [DW-1:0] out_data;
  logic          out_hsync;
  logic          out_vsync;

  modport slave (
    input  sel_req,
    input  sel_src,
    output sel_busy,
    output sw_done,
    output sw_err,
    output fallback,
    output cur_src,
    input  s0_de,
    input  s0_data,
    input  s0_hsync,
    input  s0_vsync,
    input  s1_de,
    input  s1_data,
    input  s1_hsync,
    input  s1_vsync,
    output pg_rstn,
    output out_de,
    output out_data,
    output out_hsync,
    output out_vsync
  );

  modport master (
    output sel_req,
    output sel_src,
    input  sel_busy,
    input  sw_done,
    input  sw_err,
    input  fallback,
    input  cur_src,
    output s0_de,
    output s0_data,
    output s0_hsync,
    output s0_vsync,
    output s1_de,
    output s1_data,
    output s1_hsync,
    output s1_vsync,
    input  pg_rstn,
    input  out_de,
    input  out_data,
    input  out_hsync,
    input  out_vsync
  );

endinterface

// File: rtl/video_src_arbiter.sv
// Frame-synchronous selector between sensor (source 0) and test pattern (source 1).
// Define VSA_AUTO_FALLBACK_EN to enable the sensor watchdog and automatic pattern fallback.
module video_src_arbiter #(
  parameter int unsigned   DW      = 10,
  parameter int unsigned   TW      = 24,
  parameter logic [TW-1:0] TIMEOUT = TW'(4_000_000),
  parameter bit            RST_SRC = 1'b1
) (
  input logic                clk,
  input logic                rstn,
  video_src_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StWaitEnd = 2'd1,
    StBlank   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          tgt_q, tgt_d;
  logic          cur_q, cur_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] cnt_inc;

  logic          vs0_q, vs1_q;
  logic          rise0, rise1, fall0, fall1;
  logic          cur_rise, tgt_fall;
  logic          expired;
  logic          run_wdog;

  logic          done_pend_q, done_pend_d;
  logic          same_done;
  logic          sw_done_q, sw_done_d;
  logic          sw_err_q, sw_err_d;
  logic          pg_rstn_q, pg_rstn_d;

  logic          out_de_q, out_de_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_hs_q, out_hs_d;
  logic          out_vs_q, out_vs_d;

  //////////////////////
  // Vsync edge detect //
  //////////////////////

  always_comb begin
    rise0    = bus.s0_vsync & ~vs0_q;
    fall0    = ~bus.s0_vsync & vs0_q;
    rise1    = bus.s1_vsync & ~vs1_q;
    fall1    = ~bus.s1_vsync & vs1_q;
    cur_rise = cur_q ? rise1 : rise0;
    tgt_fall = tgt_q ? fall1 : fall0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vs0_q <= 1'b0;
      vs1_q <= 1'b0;
    end else begin
      vs0_q <= bus.s0_vsync;
      vs1_q <= bus.s1_vsync;
    end
  end

  //////////////////////
  // Timeout watchdog //
  //////////////////////

  assign cnt_inc = (cnt_q == {TW{1'b1}}) ? cnt_q : cnt_q + TW'(1);
  assign expired = (cnt_q >= TIMEOUT);

  // The RUN watchdog only exists while the sensor is driving the output.
`ifdef VSA_AUTO_FALLBACK_EN
  assign run_wdog = (state_q == StRun) & ~cur_q & expired;
`else
  assign run_wdog = 1'b0;
`endif

  /////////////////////
  // Switch sequencer //
  /////////////////////

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    cur_d       = cur_q;
    cnt_d       = cnt_q;
    done_pend_d = 1'b0;
    same_done   = 1'b0;
    sw_err_d    = 1'b0;

    unique case (state_q)
      StRun: begin
        if (!cur_q) begin
          cnt_d = rise0 ? '0 : cnt_inc;
        end
        // Watchdog beats a coincident request; the request is dropped.
        if (run_wdog) begin
          state_d  = StBlank;
          tgt_d    = 1'b1;
          cnt_d    = '0;
          sw_err_d = 1'b1;
        end else if (bus.sel_req) begin
          tgt_d = bus.sel_src;
          if (bus.sel_src == cur_q) begin
            same_done = 1'b1;
          end else begin
            state_d = StWaitEnd;
            cnt_d   = '0;
          end
        end
      end

      StWaitEnd: begin
        if (cur_rise) begin
          state_d = StBlank;
          cnt_d   = '0;
        end
      end

      StBlank: begin
        cnt_d = cnt_inc;
        if (tgt_fall) begin
          state_d     = StRun;
          cur_d       = tgt_q;
          cnt_d       = '0;
          done_pend_d = 1'b1;
        end else if (expired) begin
          // A sensor that never locks is abandoned in favour of the pattern.
          tgt_d    = 1'b1;
          cnt_d    = '0;
          sw_err_d = 1'b1;
        end
      end

      default: begin
        state_d = StBlank;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StBlank;
      tgt_q       <= RST_SRC;
      cur_q       <= RST_SRC;
      cnt_q       <= '0;
      done_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      cur_q       <= cur_d;
      cnt_q       <= cnt_d;
      done_pend_q <= done_pend_d;
    end
  end

  ////////////////////
  // Status outputs //
  ////////////////////

  // A completed switch is reported together with its first output sample, one cycle
  // after the sequencer has already moved cur_src.
  assign sw_done_d = done_pend_q | same_done;

  // The pattern generator only leaves reset once BLANK is committed to it, so every
  // pattern frame selected from the sensor starts from a clean generator.
  assign pg_rstn_d = (state_q == StBlank) ? tgt_q : cur_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sw_done_q <= 1'b0;
      sw_err_q  <= 1'b0;
      pg_rstn_q <= RST_SRC;
    end else begin
      sw_done_q <= sw_done_d;
      sw_err_q  <= sw_err_d;
      pg_rstn_q <= pg_rstn_d;
    end
  end

`ifdef VSA_AUTO_FALLBACK_EN
  logic fallback_q, fallback_d;

  always_comb begin
    fallback_d = fallback_q;
    if (run_wdog) begin
      fallback_d = 1'b1;
    end else if (sw_done_d && !cur_q) begin
      fallback_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fallback_q <= 1'b0;
    end else begin
      fallback_q <= fallback_d;
    end
  end

  assign bus.fallback = fallback_q;
`else
  assign bus.fallback = 1'b0;
`endif

  ////////////////
  // Video path //
  ////////////////

  always_comb begin
    out_de_d   = 1'b0;
    out_data_d = '0;
    out_hs_d   = 1'b0;
    out_vs_d   = 1'b1;
    if (state_q != StBlank) begin
      if (cur_q) begin
        out_de_d   = bus.s1_de;
        out_data_d = bus.s1_data;
        out_hs_d   = bus.s1_hsync;
        out_vs_d   = bus.s1_vsync;
      end else begin
        out_de_d   = bus.s0_de;
        out_data_d = bus.s0_data;
        out_hs_d   = bus.s0_hsync;
        out_vs_d   = bus.s0_vsync;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_de_q   <= 1'b0;
      out_data_q <= '0;
      out_hs_q   <= 1'b0;
      out_vs_q   <= 1'b0;
    end else begin
      out_de_q   <= out_de_d;
      out_data_q <= out_data_d;
      out_hs_q   <= out_hs_d;
      out_vs_q   <= out_vs_d;
    end
  end

  assign bus.sel_busy  = (state_q != StRun);
  assign bus.sw_done   = sw_done_q;
  assign bus.sw_err    = sw_err_q;
  assign bus.cur_src   = cur_q;
  assign bus.pg_rstn   = pg_rstn_q;
  assign bus.out_de    = out_de_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_hsync = out_hs_q;
  assign bus.out_vsync = out_vs_q;

endmodule

// File: tb/tb_video_src_arbiter.sv
// Randomized bench for video_src_arbiter: frame-generating sources, random switch requests,
// stalls and resets, compared every cycle against a reference model of the switching rules.
module tb_video_src_arbiter;

  localparam int unsigned DW      = 10;
  localparam int unsigned TW      = 24;
  localparam int          TO      = 200;
  localparam bit          RST_SRC = 1'b1;
  localparam int          NCYC    = 30000;
`ifdef VSA_AUTO_FALLBACK_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int MRUN   = 0;
  localparam int MWAIT  = 1;
  localparam int MBLANK = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  video_src_arbiter_if #(.DW(DW)) bus ();

  video_src_arbiter #(
    .DW     (DW),
    .TW     (TW),
    .TIMEOUT(TW'(TO)),
    .RST_SRC(RST_SRC)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h (time %0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- reference model ----------------
  int            cyc     = 0;
  bit            chk_en  = 1'b0;
  int            m_mode;
  bit            m_cur, m_tgt, m_fb;
  int            m_since;
  bit            m_pvs [2];
  bit [2:0]      done_sched;
  bit            e_de, e_hs, e_vs, e_err, e_pg, e_done;
  logic [DW-1:0] e_data;

  always @(posedge clk) begin : model
    bit vs [2];
    bit rise [2];
    bit fall [2];
    int age;
    bit timed_out;
    if (!rstn) begin
      m_mode     = MBLANK;
      m_cur      = RST_SRC;
      m_tgt      = RST_SRC;
      m_fb       = 1'b0;
      m_since    = cyc + 1;
      m_pvs[0]   = 1'b0;
      m_pvs[1]   = 1'b0;
      done_sched = '0;
      {e_de, e_hs, e_vs, e_err, e_done} = '0;
      e_data     = '0;
      e_pg       = RST_SRC;
    end else begin
      vs[0] = bus.s0_vsync;
      vs[1] = bus.s1_vsync;
      for (int i = 0; i < 2; i++) begin
        rise[i] = vs[i] && !m_pvs[i];
        fall[i] = !vs[i] && m_pvs[i];
      end
      // Output during the next cycle follows the mode in force now.
      if (m_mode == MBLANK) begin
        e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b1; e_data = '0;
      end else if (m_cur) begin
        e_de = bus.s1_de; e_hs = bus.s1_hsync; e_vs = bus.s1_vsync; e_data = bus.s1_data;
      end else begin
        e_de = bus.s0_de; e_hs = bus.s0_hsync; e_vs = bus.s0_vsync; e_data = bus.s0_data;
      end
      e_pg       = (m_mode == MBLANK) ? m_tgt : m_cur;
      age        = cyc - m_since;
      timed_out  = (age >= TO);
      e_err      = 1'b0;
      done_sched = done_sched >> 1;
      case (m_mode)
        MRUN: begin
          if (!m_cur && rise[0]) m_since = cyc + 1;
          if (AUTO && !m_cur && timed_out) begin
            m_mode = MBLANK; m_tgt = 1'b1; m_fb = 1'b1; e_err = 1'b1; m_since = cyc + 1;
          end else if (bus.sel_req) begin
            m_tgt = bus.sel_src;
            if (bus.sel_src == m_cur) done_sched[0] = 1'b1;
            else begin
              m_mode = MWAIT; m_since = cyc + 1;
            end
          end
        end
        MWAIT: begin
          if (rise[m_cur]) begin
            m_mode = MBLANK; m_since = cyc + 1;
          end
        end
        default: begin
          if (fall[m_tgt]) begin
            m_mode = MRUN; m_cur = m_tgt; done_sched[1] = 1'b1; m_since = cyc + 1;
          end else if (timed_out) begin
            e_err = 1'b1; m_tgt = 1'b1; m_since = cyc + 1;
          end
        end
      endcase
      e_done = done_sched[0];
      if (e_done && !m_cur && !e_err) m_fb = 1'b0;
      m_pvs = vs;
    end
    cyc++;
    chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_val("out", 32'({bus.out_de, bus.out_hsync, bus.out_vsync, bus.out_data}),
                32'({e_de, e_hs, e_vs, e_data}));
      check_val("ctl", 32'({bus.sel_busy, bus.cur_src, bus.pg_rstn, bus.fallback}),
                32'({m_mode != MRUN, m_cur, e_pg, AUTO && m_fb}));
      check_val("sw_done", 32'(bus.sw_done), 32'(e_done));
      check_val("sw_err", 32'(bus.sw_err), 32'(e_err));
    end
  end

  // ---------------- stimulus ----------------
  int pos [2];
  int per [2];
  int stall_left [2];
  bit last_vs [2];

  task automatic step_src(input int i, output logic vs, output logic hs, output logic de,
                          output logic [DW-1:0] d);
    if (i == 1 && bus.pg_rstn !== 1'b1) begin
      // Pattern generator held in reset restarts at pixel 0.
      pos[1] = 0; vs = 1'b0; hs = 1'b0; de = 1'b0; d = '0;
    end else begin
      if (stall_left[i] > 0) begin
        stall_left[i]--;
        vs = last_vs[i];
      end else begin
        pos[i]++;
        if (pos[i] >= per[i]) begin
          pos[i] = 0;
          per[i] = $urandom_range(40, 120);
        end
        vs = (pos[i] < 4);
        if ($urandom_range(0, (i == 0) ? 400 : 1500) == 0) stall_left[i] = $urandom_range(50, 500);
      end
      hs = ((pos[i] % 16) < 2);
      de = (pos[i] >= 8) && ((pos[i] % 16) >= 4);
      d  = DW'($urandom);
    end
    last_vs[i] = vs;
  endtask

  task automatic drive_srcs();
    step_src(0, bus.s0_vsync, bus.s0_hsync, bus.s0_de, bus.s0_data);
    step_src(1, bus.s1_vsync, bus.s1_hsync, bus.s1_de, bus.s1_data);
  endtask

  initial begin
    int rst_left;
    bit blank_rst_done;
    rst_left       = 0;
    blank_rst_done = 1'b0;
    bus.sel_req    = 1'b0;
    bus.sel_src    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pos[i] = 0; per[i] = 60; stall_left[i] = 0; last_vs[i] = 1'b0;
    end
    drive_srcs();
    repeat (3) begin
      @(posedge clk);
      #1;
      drive_srcs();
    end
    rstn = 1'b1;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      bus.sel_req = 1'b0;
      if (rst_left > 0) rst_left--;
      else if (!blank_rst_done && c > NCYC / 3 && bus.sel_busy && bus.out_vsync && !bus.out_de)
      begin
        rst_left       = 1;
        blank_rst_done = 1'b1;
      end else if ($urandom_range(0, 5999) == 0) rst_left = $urandom_range(1, 3);
      rstn = (rst_left == 0);
      if (rstn && $urandom_range(0, 79) == 0) begin
        bus.sel_req = 1'b1;
        bus.sel_src = 1'($urandom_range(0, 1));
      end
      drive_srcs();
    end
    check_val("blank_rst_hit", 32'(blank_rst_done), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
